fetch_unit: RTL and testbench

Instruction fetch and program-counter sequencer for the 4-bit-opcode microprocessor. It sits directly upstream of the control unit. It fetches 16-bit instructions from instruction memory with a valid handshake and holds each one in an instruction register. It presents the opcode field to the control unit, then consumes that unit's PC-related control bits (LPC, SPC2/SPC1, BRCE, BRCNE) to compute the next PC. It also implements the HLT/resume halt state.

---
 rtl/fetch_unit.sv | 155 +++++++++++++++
 tb/tb_fetch_unit.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// ---------------------------------------------------------------------------
// fetch_unit
//
// Instruction fetch and program-counter sequencer for the 4-bit-opcode
// microprocessor. It fetches one instruction at a time into the instruction
// register (IR) and presents the opcode to the control unit. It then uses
// that unit's PC control bits to pick the next PC. An HLT instruction parks
// the unit in HALT until resume is asserted.
//
// Handshake: imem_req is high for every cycle the unit is in FETCH, and
// imem_addr is held stable for all of that time. A transfer completes on the
// rising edge where imem_req and imem_valid are both high. imem_valid is
// ignored in every other state.
//
// Ports:
//   clk, rst_n            clock (rising edge); asynchronous active-low reset
//   imem_req / imem_addr  fetch request and address (the current PC)
//   imem_valid/imem_rdata instruction memory response
//   instr / opcode        IR contents and IR[15:12] for the control unit
//   instr_valid           high while the IR holds an instruction in EXEC
//   ctrl_lpc, ctrl_spc    load-PC enable and PC source select
//   ctrl_brce, ctrl_brcne branch-if-equal / branch-if-not-equal enables
//   alu_zero, rs_value    branch condition and jump-register target
//   ex_stall              holds EXEC while downstream is busy
//   resume                leaves HALT
//   pc_plus1              PC+1, used as the JAL link value
//   halted                high while in HALT
// ---------------------------------------------------------------------------
module fetch_unit #(
  parameter int PC_W    = 8,
  parameter int INSTR_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic               imem_req,
  output logic [PC_W-1:0]    imem_addr,
  input  logic               imem_valid,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic [INSTR_W-1:0] instr,
  output logic [3:0]         opcode,
  output logic               instr_valid,
  input  logic               ctrl_lpc,
  input  logic [1:0]         ctrl_spc,
  input  logic               ctrl_brce,
  input  logic               ctrl_brcne,
  input  logic               alu_zero,
  input  logic [PC_W-1:0]    rs_value,
  input  logic               ex_stall,
  input  logic               resume,
  output logic [PC_W-1:0]    pc_plus1,
  output logic               halted
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    EXEC  = 2'd2,
    HALT  = 2'd3
  } state_t;

  localparam logic [3:0]         OP_HLT   = 4'hF;
  // The IR resets to a NOP so the control unit sees a harmless opcode.
  localparam logic [INSTR_W-1:0] IR_RESET = {4'hE, {(INSTR_W-4){1'b0}}};

  state_t               state_q, state_d;
  logic [PC_W-1:0]      pc_q, pc_d;
  logic [INSTR_W-1:0]   ir_q, ir_d;
  logic                 halted_q, halted_d;

  logic [PC_W-1:0]      pc_inc;
  logic [PC_W-1:0]      br_off;
  logic [PC_W-1:0]      br_target;
  logic [PC_W-1:0]      jmp_target;
  logic                 br_taken;

  // All PC arithmetic wraps modulo 2^PC_W.
  assign pc_inc     = pc_q + PC_W'(1);
  // A size cast of a signed 8-bit value sign-extends the branch offset.
  assign br_off     = PC_W'($signed(ir_q[7:0]));
  assign br_target  = pc_inc + br_off;
  // The jump field is IR[11:0]. It is truncated to the PC width.
  assign jmp_target = ir_q[PC_W-1:0];
  assign br_taken   = (ctrl_brce & alu_zero) | (ctrl_brcne & ~alu_zero);

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    unique case (state_q)
      IDLE: begin
        state_d = FETCH;
      end
      FETCH: begin
        if (imem_valid) begin
          ir_d    = imem_rdata;
          state_d = EXEC;
        end
      end
      EXEC: begin
        if (!ex_stall) begin
          if (opcode == OP_HLT) begin
            // HLT ignores the control bits. The PC steps past the HLT so
            // that resume continues with the next instruction.
            pc_d    = pc_inc;
            state_d = HALT;
          end else begin
            state_d = FETCH;
            if (!ctrl_lpc) begin
              pc_d = pc_inc;
            end else begin
              unique case (ctrl_spc)
                2'b00:   pc_d = pc_inc;
                2'b01:   pc_d = br_taken ? br_target : pc_inc;
                2'b10:   pc_d = jmp_target;
                default: pc_d = rs_value;
              endcase
            end
          end
        end
      end
      HALT: begin
        if (resume) begin
          state_d = FETCH;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    halted_d = (state_d == HALT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      pc_q     <= '0;
      ir_q     <= IR_RESET;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      ir_q     <= ir_d;
      halted_q <= halted_d;
    end
  end

  assign imem_req    = (state_q == FETCH);
  assign instr_valid = (state_q == EXEC);
  assign imem_addr   = pc_q;
  assign instr       = ir_q;
  assign opcode      = ir_q[INSTR_W-1:INSTR_W-4];
  assign pc_plus1    = pc_inc;
  assign halted      = halted_q;

endmodule

// File: tb/tb_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_fetch_unit
//
// Directed bench for fetch_unit with PC_W=8. Each instruction is issued by a
// driver task. When that task commits the EXEC edge, it pushes the address
// of the next fetch onto exp_q. A separate monitor pops exp_q each time
// imem_req rises and compares the presented address. Cycle-level properties
// are checked inline: wait states, stalls, halt, and reset.
// ---------------------------------------------------------------------------
module tb_fetch_unit;

  localparam int PC_W    = 8;
  localparam int INSTR_W = 16;

  // -------------------------------------------------------------------------
  // clock / reset
  // -------------------------------------------------------------------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic               imem_req;
  logic [PC_W-1:0]    imem_addr;
  logic               imem_valid;
  logic [INSTR_W-1:0] imem_rdata;
  logic [INSTR_W-1:0] instr;
  logic [3:0]         opcode;
  logic               instr_valid;
  logic               ctrl_lpc;
  logic [1:0]         ctrl_spc;
  logic               ctrl_brce;
  logic               ctrl_brcne;
  logic               alu_zero;
  logic [PC_W-1:0]    rs_value;
  logic               ex_stall;
  logic               resume;
  logic [PC_W-1:0]    pc_plus1;
  logic               halted;

  fetch_unit #(.PC_W(PC_W), .INSTR_W(INSTR_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_valid (imem_valid),
    .imem_rdata (imem_rdata),
    .instr      (instr),
    .opcode     (opcode),
    .instr_valid(instr_valid),
    .ctrl_lpc   (ctrl_lpc),
    .ctrl_spc   (ctrl_spc),
    .ctrl_brce  (ctrl_brce),
    .ctrl_brcne (ctrl_brcne),
    .alu_zero   (alu_zero),
    .rs_value   (rs_value),
    .ex_stall   (ex_stall),
    .resume     (resume),
    .pc_plus1   (pc_plus1),
    .halted     (halted)
  );

  // -------------------------------------------------------------------------
  // scoreboard
  // -------------------------------------------------------------------------
  logic [PC_W-1:0] exp_q[$];
  int checks   = 0;
  int failures = 0;
  logic req_prev = 1'b0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every new fetch request must match the next expected address.
  always @(negedge clk) begin
    logic [PC_W-1:0] e;
    if (imem_req === 1'b1 && req_prev !== 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_fetch: got addr %0h expected no fetch at %0t",
                 imem_addr, $time);
      end else begin
        e = exp_q.pop_front();
        check("fetch_addr", imem_addr, e);
      end
    end
    req_prev = imem_req;
  end

  // -------------------------------------------------------------------------
  // driver tasks (all called at a negedge, return at a negedge)
  // -------------------------------------------------------------------------
  task automatic wait_fetch();
    int n = 0;
    while (imem_req !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("fetch_req", imem_req, 1);
  endtask

  // Supplies one instruction after `waits` empty cycles. It returns in EXEC.
  task automatic fetch(input logic [15:0] rdata, input int waits,
                       input logic [7:0] exp_p1);
    logic [PC_W-1:0]    a  = imem_addr;
    logic [INSTR_W-1:0] ir0 = instr;
    for (int i = 0; i < waits; i++) begin
      imem_valid = 1'b0;
      imem_rdata = 16'hDEAD;
      @(negedge clk);
      check("wait_req", imem_req, 1);
      check("wait_addr", imem_addr, a);
      check("wait_ir", instr, ir0);
    end
    imem_valid = 1'b1;
    imem_rdata = rdata;
    @(negedge clk);
    imem_valid = 1'b0;
    imem_rdata = 16'hBEEF;
    check("exec_valid", instr_valid, 1);
    check("ir", instr, rdata);
    check("opcode", opcode, rdata[15:12]);
    check("pc_plus1", pc_plus1, exp_p1);
  endtask

  // Holds EXEC for `stalls` cycles, then commits with the given controls.
  task automatic exec(input int stalls, input logic lpc, input logic [1:0] spc,
                      input logic brce, input logic brcne, input logic zero,
                      input logic [7:0] rs, input logic [7:0] next_pc,
                      input bit is_hlt);
    logic [PC_W-1:0] a = imem_addr;
    for (int i = 0; i < stalls; i++) begin
      ex_stall = 1'b1;
      ctrl_lpc = 1'b1;
      ctrl_spc = 2'b11;
      rs_value = 8'h77;
      @(negedge clk);
      check("stall_valid", instr_valid, 1);
      check("stall_pc", imem_addr, a);
      check("stall_req", imem_req, 0);
    end
    ex_stall   = 1'b0;
    ctrl_lpc   = lpc;
    ctrl_spc   = spc;
    ctrl_brce  = brce;
    ctrl_brcne = brcne;
    alu_zero   = zero;
    rs_value   = rs;
    if (!is_hlt) exp_q.push_back(next_pc);
    @(negedge clk);
    ctrl_lpc   = 1'b0;
    ctrl_spc   = 2'b00;
    ctrl_brce  = 1'b0;
    ctrl_brcne = 1'b0;
    alu_zero   = 1'b0;
    rs_value   = '0;
    if (is_hlt) begin
      check("halt_halted", halted, 1);
      check("halt_req", imem_req, 0);
      check("halt_pc", imem_addr, next_pc);
    end else begin
      check("refetch_req", imem_req, 1);
    end
  endtask

  task automatic run_instr(input logic [15:0] rdata, input int waits,
                           input int stalls, input logic lpc,
                           input logic [1:0] spc, input logic brce,
                           input logic brcne, input logic zero,
                           input logic [7:0] rs, input logic [7:0] exp_p1,
                           input logic [7:0] next_pc, input bit is_hlt);
    wait_fetch();
    fetch(rdata, waits, exp_p1);
    exec(stalls, lpc, spc, brce, brcne, zero, rs, next_pc, is_hlt);
  endtask

  // -------------------------------------------------------------------------
  // stimulus
  // -------------------------------------------------------------------------
  initial begin
    rst_n      = 1'b0;
    imem_valid = 1'b0;
    imem_rdata = '0;
    ctrl_lpc   = 1'b0;
    ctrl_spc   = 2'b00;
    ctrl_brce  = 1'b0;
    ctrl_brcne = 1'b0;
    alu_zero   = 1'b0;
    rs_value   = '0;
    ex_stall   = 1'b0;
    resume     = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_req", imem_req, 0);
    check("rst_valid", instr_valid, 0);
    check("rst_halted", halted, 0);
    check("rst_opcode", opcode, 4'hE);
    check("rst_instr", instr, 16'hE000);
    check("rst_addr", imem_addr, 0);

    // First instruction: request one cycle after release, EXEC the next.
    exp_q.push_back(8'h00);
    rst_n = 1'b1;
    @(negedge clk);
    check("req_cycle1", imem_req, 1);
    fetch(16'h0123, 0, 8'h01);
    exec(0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 8'h00, 8'h01, 1'b0);

    // 3 imem wait states, then 2 stall cycles.
    run_instr(16'h1000, 3, 2, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 8'h00, 8'h02, 8'h02, 1'b0);
    // J to 8, with resume high throughout (resume is ignored outside HALT).
    resume = 1'b1;
    run_instr(16'h8008, 0, 0, 1'b1, 2'b10, 1'b0, 1'b0, 1'b0, 8'h00, 8'h03, 8'h08, 1'b0);
    resume = 1'b0;
    // BEQ at 8, offset -4, taken: 9-4=5.
    run_instr(16'h90FC, 0, 0, 1'b1, 2'b01, 1'b1, 1'b0, 1'b1, 8'h00, 8'h09, 8'h05, 1'b0);
    run_instr(16'h8008, 0, 0, 1'b1, 2'b10, 1'b0, 1'b0, 1'b0, 8'h00, 8'h06, 8'h08, 1'b0);
    // BEQ at 8, not taken: 9.
    run_instr(16'h90FC, 0, 0, 1'b1, 2'b01, 1'b1, 1'b0, 1'b0, 8'h00, 8'h09, 8'h09, 1'b0);
    run_instr(16'h8008, 0, 0, 1'b1, 2'b10, 1'b0, 1'b0, 1'b0, 8'h00, 8'h0A, 8'h08, 1'b0);
    // BNE at 8, offset +2, taken: 9+2=11.
    run_instr(16'hA002, 0, 0, 1'b1, 2'b01, 1'b0, 1'b1, 1'b0, 8'h00, 8'h09, 8'h0B, 1'b0);
    // J to IR[11:0]=0A5.
    run_instr(16'h80A5, 0, 0, 1'b1, 2'b10, 1'b0, 1'b0, 1'b0, 8'h00, 8'h0C, 8'hA5, 1'b0);
    // J with IR[11:0]=F20, which truncates to 20.
    run_instr(16'h8F20, 0, 0, 1'b1, 2'b10, 1'b0, 1'b0, 1'b0, 8'h00, 8'hA6, 8'h20, 1'b0);
    // JAL at 20 to FF: link value 21.
    run_instr(16'hB0FF, 0, 0, 1'b1, 2'b10, 1'b0, 1'b0, 1'b0, 8'h00, 8'h21, 8'hFF, 1'b0);
    // NOP at FF with lpc=0 wraps to 0. pc_plus1 is 00 as well.
    run_instr(16'hE000, 0, 0, 1'b0, 2'b10, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0);
    // JR at 0 with rs_value=3C.
    run_instr(16'hC000, 0, 0, 1'b1, 2'b11, 1'b0, 1'b0, 1'b0, 8'h3C, 8'h01, 8'h3C, 1'b0);
    // UNDEF with lpc=1, spc=00 steps by one.
    run_instr(16'hD0FF, 0, 0, 1'b1, 2'b00, 1'b1, 1'b1, 1'b1, 8'h99, 8'h3D, 8'h3D, 1'b0);
    // Backward branch with a large offset: 3E + (-0x2E) = 10.
    run_instr(16'h90D2, 0, 0, 1'b1, 2'b01, 1'b0, 1'b1, 1'b0, 8'h00, 8'h3E, 8'h10, 1'b0);
    // HLT at 10 with jump-like controls, which must be ignored.
    run_instr(16'hF0AA, 0, 1, 1'b1, 2'b10, 1'b0, 1'b0, 1'b0, 8'h55, 8'h11, 8'h11, 1'b1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("halt_hold", halted, 1);
      check("halt_noreq", imem_req, 0);
    end
    exp_q.push_back(8'h11);
    resume = 1'b1;
    @(negedge clk);
    resume = 1'b0;
    check("resume_req", imem_req, 1);
    check("resume_halted", halted, 0);
    run_instr(16'h8040, 0, 0, 1'b1, 2'b10, 1'b0, 1'b0, 1'b0, 8'h00, 8'h12, 8'h40, 1'b0);

    // Reset in the middle of the fetch at 40.
    wait_fetch();
    imem_valid = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_req", imem_req, 0);
    check("midrst_addr", imem_addr, 0);
    check("midrst_opcode", opcode, 4'hE);
    check("midrst_valid", instr_valid, 0);
    imem_valid = 1'b1;
    imem_rdata = 16'h1234;
    @(negedge clk);
    exp_q.push_back(8'h00);
    rst_n = 1'b1;
    @(negedge clk);
    // The late imem_valid landed while the unit was in IDLE and was dropped.
    check("late_valid_ir", instr, 16'hE000);
    check("late_valid_req", imem_req, 1);
    fetch(16'hE000, 0, 8'h01);
    exec(0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 8'h00, 8'h01, 1'b0);

    repeat (3) @(negedge clk);
    check("queue_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected end before 200000");
    $fatal(1, "watchdog");
  end

endmodule
